// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared encodings for the IFU/LSU memory-port arbiter.
//   state_e : arbiter FSM states (idle, busy serving IFU, busy serving LSU)
//   owner_e : requester identity, also used to remember the last granted owner
// Optional feature macro used by the arbiter: CONFIG_ARB_RR_EN.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StBusyIfu = 2'd1,
    StBusyLsu = 2'd2
  } state_e;

  typedef enum logic {
    OwnIfu = 1'b0,
    OwnLsu = 1'b1
  } owner_e;

endpackage

// File: rtl/arb_grant_sel.sv
// arb_grant_sel: combinational winner selection between the IFU and the LSU.
// Ports:
//   ifu_valid_i, lsu_valid_i : request valids
//   last_owner_i             : requester granted most recently
//   grant_ifu_o, grant_lsu_o : one-hot (or all-zero) winner
// Macro CONFIG_ARB_RR_EN: defined -> round-robin on contention (the requester
// that was not last_owner wins); undefined -> fixed priority, LSU over IFU.
module arb_grant_sel
  import mem_bus_arbiter_pkg::*;
(
  input  logic   ifu_valid_i,
  input  logic   lsu_valid_i,
  input  owner_e last_owner_i,
  output logic   grant_ifu_o,
  output logic   grant_lsu_o
);

`ifdef CONFIG_ARB_RR_EN
  always_comb begin
    grant_ifu_o = 1'b0;
    grant_lsu_o = 1'b0;
    if (ifu_valid_i && lsu_valid_i) begin
      if (last_owner_i == OwnLsu) begin
        grant_ifu_o = 1'b1;
      end else begin
        grant_lsu_o = 1'b1;
      end
    end else begin
      grant_ifu_o = ifu_valid_i;
      grant_lsu_o = lsu_valid_i;
    end
  end
`else
  assign grant_lsu_o = lsu_valid_i;
  assign grant_ifu_o = ifu_valid_i & ~lsu_valid_i;

  // last_owner is still tracked upstream but plays no role in fixed priority.
  logic unused_last_owner;
  assign unused_last_owner = last_owner_i;
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between the IFU (read-only) and the
// LSU (read/write). One requester is granted at a time; the grant is held
// until the memory response returns, which is routed to that owner only.
// Ports:
//   clk_i, rst_i                         : clock, async active-high reset
//   ifu_req_*/ifu_addr_i, ifu_resp_*     : IFU read request / response
//   lsu_req_*/lsu_addr/wdata/wmask_i,
//   lsu_resp_*                           : LSU request (wmask==0 is a read) / response
//   mem_req_*/mem_addr/wdata/wmask_o     : forwarded request to memory
//   mem_resp_valid_i, mem_rdata_i        : memory response (single-cycle pulse)
// Macro CONFIG_ARB_RR_EN selects round-robin arbitration (see arb_grant_sel).
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned MASK_W = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ifu_req_valid_i,
  output logic              ifu_req_ready_o,
  input  logic [ADDR_W-1:0] ifu_addr_i,
  output logic              ifu_resp_valid_o,
  output logic [DATA_W-1:0] ifu_rdata_o,
  input  logic              lsu_req_valid_i,
  output logic              lsu_req_ready_o,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [DATA_W-1:0] lsu_wdata_i,
  input  logic [MASK_W-1:0] lsu_wmask_i,
  output logic              lsu_resp_valid_o,
  output logic [DATA_W-1:0] lsu_rdata_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [MASK_W-1:0] mem_wmask_o,
  input  logic              mem_resp_valid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  state_e state_q, state_d;
  owner_e last_owner_q, last_owner_d;

  logic sel_ifu, sel_lsu;
  logic idle, gnt_ifu, gnt_lsu, accept;

  arb_grant_sel u_grant_sel (
    .ifu_valid_i  (ifu_req_valid_i),
    .lsu_valid_i  (lsu_req_valid_i),
    .last_owner_i (last_owner_q),
    .grant_ifu_o  (sel_ifu),
    .grant_lsu_o  (sel_lsu)
  );

  // A grant only exists in IDLE; BUSY states keep requesters waiting.
  assign idle    = (state_q == StIdle);
  assign gnt_ifu = idle & sel_ifu;
  assign gnt_lsu = idle & sel_lsu;
  assign accept  = mem_req_valid_o & mem_req_ready_i;

  assign mem_req_valid_o = gnt_ifu | gnt_lsu;
  assign mem_addr_o      = gnt_lsu ? lsu_addr_i : (gnt_ifu ? ifu_addr_i : '0);
  // IFU is read-only, so its forwarded wdata/wmask are zero.
  assign mem_wdata_o     = gnt_lsu ? lsu_wdata_i : '0;
  assign mem_wmask_o     = gnt_lsu ? lsu_wmask_i : '0;

  assign ifu_req_ready_o = gnt_ifu & mem_req_ready_i;
  assign lsu_req_ready_o = gnt_lsu & mem_req_ready_i;

  // Responses reach only the current owner; one arriving in IDLE is dropped.
  assign ifu_resp_valid_o = (state_q == StBusyIfu) & mem_resp_valid_i;
  assign lsu_resp_valid_o = (state_q == StBusyLsu) & mem_resp_valid_i;
  assign ifu_rdata_o      = ifu_resp_valid_o ? mem_rdata_i : '0;
  assign lsu_rdata_o      = lsu_resp_valid_o ? mem_rdata_i : '0;

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (gnt_lsu) begin
            state_d      = StBusyLsu;
            last_owner_d = OwnLsu;
          end else begin
            state_d      = StBusyIfu;
            last_owner_d = OwnIfu;
          end
        end
      end
      StBusyIfu, StBusyLsu: begin
        if (mem_resp_valid_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      last_owner_q <= OwnIfu;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter. Expected transactions are queued when a
// request is driven, checked against the memory side when granted, then moved
// to a response queue and checked against the requester side on response.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_resp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    owner_e      owner;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
  } txn_t;

  txn_t req_q[$];
  txn_t resp_q[$];

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .ifu_req_valid_i  (ifu_req_valid),
    .ifu_req_ready_o  (ifu_req_ready),
    .ifu_addr_i       (ifu_addr),
    .ifu_resp_valid_o (ifu_resp_valid),
    .ifu_rdata_o      (ifu_rdata),
    .lsu_req_valid_i  (lsu_req_valid),
    .lsu_req_ready_o  (lsu_req_ready),
    .lsu_addr_i       (lsu_addr),
    .lsu_wdata_i      (lsu_wdata),
    .lsu_wmask_i      (lsu_wmask),
    .lsu_resp_valid_o (lsu_resp_valid),
    .lsu_rdata_o      (lsu_rdata),
    .mem_req_valid_o  (mem_req_valid),
    .mem_req_ready_i  (mem_req_ready),
    .mem_addr_o       (mem_addr),
    .mem_wdata_o      (mem_wdata),
    .mem_wmask_o      (mem_wmask),
    .mem_resp_valid_i (mem_resp_valid),
    .mem_rdata_i      (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ifu();
    ifu_req_valid = 1'b0;
    ifu_addr      = '0;
  endtask

  task automatic clear_lsu();
    lsu_req_valid = 1'b0;
    lsu_addr      = '0;
    lsu_wdata     = '0;
    lsu_wmask     = '0;
  endtask

  task automatic drive_req(input txn_t t);
    if (t.owner == OwnIfu) begin
      ifu_req_valid = 1'b1;
      ifu_addr      = t.addr;
    end else begin
      lsu_req_valid = 1'b1;
      lsu_addr      = t.addr;
      lsu_wdata     = t.wdata;
      lsu_wmask     = t.wmask;
    end
  endtask

  // Current cycle must be the grant cycle of the oldest queued request.
  task automatic accept_check();
    txn_t t;
    #1;
    if (req_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL req_q: observed empty expected pending request");
      return;
    end
    t = req_q.pop_front();
    chk("mem_req_valid", 32'(mem_req_valid), 32'd1);
    chk("ifu_req_ready", 32'(ifu_req_ready), 32'(t.owner == OwnIfu));
    chk("lsu_req_ready", 32'(lsu_req_ready), 32'(t.owner == OwnLsu));
    chk("mem_addr", mem_addr, t.addr);
    chk("mem_wdata", mem_wdata, t.wdata);
    chk("mem_wmask", 32'(mem_wmask), 32'(t.wmask));
    resp_q.push_back(t);
  endtask

  // Pulse a memory response for the oldest granted transaction.
  task automatic resp_cycle();
    txn_t t;
    if (resp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL resp_q: observed empty expected outstanding response");
      return;
    end
    t = resp_q.pop_front();
    mem_resp_valid = 1'b1;
    mem_rdata      = t.rdata;
    #1;
    chk("ifu_resp_valid", 32'(ifu_resp_valid), 32'(t.owner == OwnIfu));
    chk("lsu_resp_valid", 32'(lsu_resp_valid), 32'(t.owner == OwnLsu));
    chk("ifu_rdata", ifu_rdata, (t.owner == OwnIfu) ? t.rdata : 32'd0);
    chk("lsu_rdata", lsu_rdata, (t.owner == OwnLsu) ? t.rdata : 32'd0);
    tick();
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
  endtask

  // One complete transaction: stall cycles of backpressure, then grant, then
  // lat busy cycles with the response arriving in the last of them.
  task automatic single_txn(input txn_t t, input int stall, input int lat);
    drive_req(t);
    req_q.push_back(t);
    mem_req_ready = (stall == 0);
    for (int i = 0; i < stall; i++) begin
      #1;
      chk("bp_mem_req_valid", 32'(mem_req_valid), 32'd1);
      chk("bp_ifu_req_ready", 32'(ifu_req_ready), 32'd0);
      chk("bp_lsu_req_ready", 32'(lsu_req_ready), 32'd0);
      tick();
    end
    mem_req_ready = 1'b1;
    accept_check();
    tick();
    clear_ifu();
    clear_lsu();
    for (int i = 1; i < lat; i++) begin
      #1;
      chk("busy_mem_req_valid", 32'(mem_req_valid), 32'd0);
      chk("busy_resp_valid", 32'({ifu_resp_valid, lsu_resp_valid}), 32'd0);
      tick();
    end
    resp_cycle();
  endtask

  // Both requesters valid together; the LSU is expected to win first here
  // (fixed priority, and under round-robin the IFU owned the port last).
  task automatic simul_round(input txn_t li, input txn_t ii);
    drive_req(li);
    drive_req(ii);
    req_q.push_back(li);
    req_q.push_back(ii);
    mem_req_ready = 1'b1;
    accept_check();
    tick();
    clear_lsu();
    #1;
    chk("wait_ifu_req_ready", 32'(ifu_req_ready), 32'd0);
    chk("wait_mem_req_valid", 32'(mem_req_valid), 32'd0);
    resp_cycle();
    accept_check();
    tick();
    clear_ifu();
    resp_cycle();
  endtask

  txn_t t;

  initial begin
    rst            = 1'b1;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
    clear_ifu();
    clear_lsu();
    tick();
    tick();
    // Reset outputs
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wmask", 32'(mem_wmask), 32'd0);
    chk("rst_req_ready", 32'({ifu_req_ready, lsu_req_ready}), 32'd0);
    chk("rst_resp_valid", 32'({ifu_resp_valid, lsu_resp_valid}), 32'd0);
    chk("rst_rdata", ifu_rdata | lsu_rdata, 32'd0);
    rst = 1'b0;
    tick();

    // IFU-only read, response two cycles after grant
    t = '{OwnIfu, 32'h8000_0000, 32'h0, 4'h0, 32'h0000_0413};
    single_txn(t, 0, 2);

    // LSU full-word write
    t = '{OwnLsu, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 32'h0};
    single_txn(t, 0, 1);

    // Backpressure on an IFU read for three cycles
    t = '{OwnIfu, 32'h8000_0004, 32'h0, 4'h0, 32'h1234_5678};
    single_txn(t, 3, 1);

    // LSU read with minimum-latency response
    t = '{OwnLsu, 32'h8000_2000, 32'h0, 4'h0, 32'hCAFE_F00D};
    single_txn(t, 0, 1);
    // Simultaneous requests leave last_owner at IFU; two rounds give LSU, IFU, LSU, IFU
    t = '{OwnIfu, 32'h8000_0008, 32'h0, 4'h0, 32'h0000_0013};
    single_txn(t, 0, 1);
    simul_round('{OwnLsu, 32'h8000_3000, 32'h1111_2222, 4'h3, 32'h0},
                '{OwnIfu, 32'h8000_000C, 32'h0, 4'h0, 32'hA5A5_0001});
    simul_round('{OwnLsu, 32'h8000_3004, 32'h0, 4'h0, 32'h5A5A_0002},
                '{OwnIfu, 32'h8000_0010, 32'h0, 4'h0, 32'hA5A5_0003});

    // Spurious response in IDLE is dropped
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'hFFFF_0000;
    #1;
    chk("spur_resp_valid", 32'({ifu_resp_valid, lsu_resp_valid}), 32'd0);
    chk("spur_rdata", ifu_rdata | lsu_rdata, 32'd0);
    tick();
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;

    // Reset during BUSY_IFU, then a late response after release
    t = '{OwnIfu, 32'h8000_0100, 32'h0, 4'h0, 32'hBAD0_BAD0};
    drive_req(t);
    req_q.push_back(t);
    mem_req_ready = 1'b1;
    accept_check();
    tick();
    clear_ifu();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    resp_q.delete();
    tick();
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'hBAD0_BAD0;
    #1;
    chk("late_resp_valid", 32'({ifu_resp_valid, lsu_resp_valid}), 32'd0);
    chk("late_rdata", ifu_rdata | lsu_rdata, 32'd0);
    tick();
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
    // Port must be free again right away
    t = '{OwnIfu, 32'h8000_0200, 32'h0, 4'h0, 32'h0BAD_F00D};
    single_txn(t, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
